// File: rtl/game_pkg.sv
// Shared game definitions: action FSM states, attack types, HID key codes
// and the frame-counter width used by the per-player action encoder.
package game_pkg;

    localparam int unsigned FRAME_CNT_W = 6;
    localparam int unsigned KEY_W       = 8;
    localparam int unsigned KEY_BYTES   = 4;
    localparam int unsigned KEYCODE_W   = KEY_W * KEY_BYTES;

    // HID usage codes
    localparam logic [KEY_W-1:0] KEY_NONE  = 8'h00;
    localparam logic [KEY_W-1:0] KEY_PUNCH = 8'h0D;
    localparam logic [KEY_W-1:0] KEY_KICK  = 8'h0E;
    localparam logic [KEY_W-1:0] KEY_BLOCK = 8'h0F;
    localparam logic [KEY_W-1:0] KEY_SHOOT = 8'h33;

    typedef enum logic [2:0] {
        IDLE,
        WINDUP,
        ACTIVE,
        RECOVER,
        WAIT_REL
    } action_state_t;

    typedef enum logic {
        ATK_PUNCH,
        ATK_KICK
    } attack_t;

    // True when any of the key bytes carries the given code; 8'h00 means "no key"
    function automatic logic key_in_word(input logic [KEYCODE_W-1:0] kc,
                                         input logic [KEY_W-1:0]     key);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(KEY_BYTES); i++) begin
            if (key != KEY_NONE && kc[i*KEY_W +: KEY_W] == key) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/player_action_encoder_key_match.sv
// Per-key detector: level "held" from the current keycode, and a one-frame
// "pressed" edge against the previous frame's held value.
module key_match
    import game_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY = KEY_PUNCH
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [KEYCODE_W-1:0] keycode,
    output logic                 held,
    output logic                 pressed
);

    logic held_prev;

    assign held    = key_in_word(keycode, KEY);
    assign pressed = held & ~held_prev;

    // Previous-frame key level, updated every frame regardless of game state
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            held_prev <= 1'b0;
        end else begin
            held_prev <= held;
        end
    end

endmodule

// File: rtl/player_action_encoder.sv
// Player action encoder: turns the raw 4-byte USB keycode into timed
// punch/kick attacks (wind-up, active, recovery), a block level, a shoot
// strobe and an animation move flag. One instance per player.
// Optional feature macro: COMBO_BUFFER_EN (one-deep attack buffer in RECOVER).
module player_action_encoder
    import game_pkg::*;
#(
    parameter logic [KEY_W-1:0] PUNCH_KEY  = KEY_PUNCH,
    parameter logic [KEY_W-1:0] KICK_KEY   = KEY_KICK,
    parameter logic [KEY_W-1:0] BLOCK_KEY  = KEY_BLOCK,
    parameter logic [KEY_W-1:0] SHOOT_KEY  = KEY_SHOOT,
    parameter int unsigned      WINDUP_FR  = 6,
    parameter int unsigned      ACTIVE_FR  = 10,
    parameter int unsigned      RECOVER_FR = 12
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic [KEYCODE_W-1:0] keycode,
    output logic                 punch,
    output logic                 kick,
    output logic                 block,
    output logic                 shoot,
    output logic                 move,
    output logic                 busy
);

    localparam logic [FRAME_CNT_W-1:0] WINDUP_LAST  = FRAME_CNT_W'(WINDUP_FR - 1);
    localparam logic [FRAME_CNT_W-1:0] ACTIVE_LAST  = FRAME_CNT_W'(ACTIVE_FR - 1);
    localparam logic [FRAME_CNT_W-1:0] RECOVER_LAST = FRAME_CNT_W'(RECOVER_FR - 1);

    action_state_t          state;
    attack_t                atk;
    logic [FRAME_CNT_W-1:0] cnt;

    logic punch_held, punch_pressed;
    logic kick_held,  kick_pressed;
    logic block_held, block_pressed;
    logic shoot_held, shoot_pressed;

    logic    any_attack_pressed;
    logic    launch;
    attack_t edge_type;
    logic    latched_held;
    logic    combo_hit;
    attack_t combo_type;
    logic    unused_key_outs;

    key_match #(.KEY(PUNCH_KEY)) u_punch_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .held      (punch_held),
        .pressed   (punch_pressed)
    );

    key_match #(.KEY(KICK_KEY)) u_kick_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .held      (kick_held),
        .pressed   (kick_pressed)
    );

    key_match #(.KEY(BLOCK_KEY)) u_block_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .held      (block_held),
        .pressed   (block_pressed)
    );

    key_match #(.KEY(SHOOT_KEY)) u_shoot_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .held      (shoot_held),
        .pressed   (shoot_pressed)
    );

    // Block is a level and shoot is an edge, so their other detector outputs go unused
    assign unused_key_outs = block_pressed ^ shoot_held;

    // Attack request decode; kick wins when both edges land in the same frame
    assign any_attack_pressed = punch_pressed | kick_pressed;
    assign launch             = any_attack_pressed & ~block_held;
    assign edge_type          = kick_pressed ? ATK_KICK : ATK_PUNCH;
    assign latched_held       = (atk == ATK_KICK) ? kick_held : punch_held;

`ifdef COMBO_BUFFER_EN
    logic    buf_valid;
    attack_t buf_type;

    // One-deep capture of the first attack edge seen while recovering
    always_ff @(posedge frame_clk) begin
        if (Reset || !enable) begin
            buf_valid <= 1'b0;
            buf_type  <= ATK_PUNCH;
        end else if (state == RECOVER && cnt != RECOVER_LAST) begin
            if (!buf_valid && any_attack_pressed) begin
                buf_valid <= 1'b1;
                buf_type  <= edge_type;
            end
        end else begin
            buf_valid <= 1'b0;
        end
    end

    // An edge on the final recovery frame counts as buffered too
    assign combo_hit  = buf_valid | any_attack_pressed;
    assign combo_type = buf_valid ? buf_type : edge_type;
`else
    assign combo_hit  = 1'b0;
    assign combo_type = ATK_PUNCH;
`endif

    // Action FSM; outputs are registered to match the state being entered
    always_ff @(posedge frame_clk) begin
        punch <= 1'b0;
        kick  <= 1'b0;
        block <= 1'b0;
        shoot <= 1'b0;
        move  <= 1'b0;
        busy  <= 1'b0;

        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            atk   <= ATK_PUNCH;
        end else if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    block <= block_held;
                    shoot <= shoot_pressed & ~block_held;
                    if (launch) begin
                        state <= WINDUP;
                        cnt   <= '0;
                        atk   <= edge_type;
                        move  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                WINDUP: begin
                    move <= 1'b1;
                    busy <= 1'b1;
                    if (cnt == WINDUP_LAST) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                        punch <= (atk == ATK_PUNCH);
                        kick  <= (atk == ATK_KICK);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ACTIVE: begin
                    busy <= 1'b1;
                    if (cnt == ACTIVE_LAST) begin
                        state <= RECOVER;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        move  <= 1'b1;
                        punch <= (atk == ATK_PUNCH);
                        kick  <= (atk == ATK_KICK);
                    end
                end

                RECOVER: begin
                    if (cnt == RECOVER_LAST) begin
                        cnt <= '0;
                        if (combo_hit) begin
                            state <= WINDUP;
                            atk   <= combo_type;
                            move  <= 1'b1;
                            busy  <= 1'b1;
                        end else if (latched_held) begin
                            state <= WAIT_REL;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt  <= cnt + 1'b1;
                        busy <= 1'b1;
                    end
                end

                WAIT_REL: begin
                    if (latched_held) begin
                        busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_action_encoder.sv
// Bench for player_action_encoder: directed scenarios plus random key
// traffic, checked every frame against a timeline-based model of attacks.
module tb_player_action_encoder;

    localparam int W = 6;
    localparam int A = 10;
    localparam int R = 12;

    logic        frame_clk;
    logic        Reset;
    logic        enable;
    logic [31:0] keycode;
    logic        punch, kick, block, shoot, move, busy;

    player_action_encoder #(
        .PUNCH_KEY  (8'h0D),
        .KICK_KEY   (8'h0E),
        .BLOCK_KEY  (8'h0F),
        .SHOOT_KEY  (8'h33),
        .WINDUP_FR  (W),
        .ACTIVE_FR  (A),
        .RECOVER_FR (R)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .enable    (enable),
        .keycode   (keycode),
        .punch     (punch),
        .kick      (kick),
        .block     (block),
        .shoot     (shoot),
        .move      (move),
        .busy      (busy)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;
    int fr     = 0;
    bit exp_valid = 0;

    // expected outputs for the frame after the last driven one
    bit e_punch, e_kick, e_block, e_shoot, e_move, e_busy;

    // observation counters for literal expectations
    int n_punch, n_kick, n_block, n_shoot, n_busy, first_punch;

    // model state: attack launched at press frame m_t0, or waiting for release
    bit m_att, m_wait, m_typ, m_buf, m_buf_typ;
    int m_t0;
    bit m_prev [4];
    logic [7:0] keys [4] = '{8'h0D, 8'h0E, 8'h0F, 8'h33};
    logic [7:0] alpha [7] = '{8'h00, 8'h00, 8'h0D, 8'h0E, 8'h0F, 8'h33, 8'h41};

    function automatic bit mheld(input logic [31:0] kc, input logic [7:0] k);
        bit hit = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'(kc >> (8 * i));
            if (k != 8'h00 && b == k) hit = 1;
        end
        return hit;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s frame %0d: got %b expected %b", nm, fr, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_punch = 0; n_kick = 0; n_block = 0; n_shoot = 0; n_busy = 0;
        first_punch = -1;
    endtask

    // Compute outputs for frame fr+1 from inputs driven during frame fr
    task automatic model(input logic r, input logic e, input logic [31:0] k);
        bit h [4];
        bit p [4];
        bit lh;
        int age, na;
        e_punch = 0; e_kick = 0; e_block = 0; e_shoot = 0; e_move = 0; e_busy = 0;
        for (int i = 0; i < 4; i++) begin
            h[i] = mheld(k, keys[i]);
            p[i] = h[i] && !m_prev[i];
        end
        lh = m_typ ? h[1] : h[0];
        if (r) begin
            m_att = 0; m_wait = 0; m_buf = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 0;
            return;
        end
        if (!e) begin
            m_att = 0; m_wait = 0; m_buf = 0;
        end else if (m_att) begin
            age = fr - m_t0;
`ifdef COMBO_BUFFER_EN
            if (age > W + A && !m_buf && (p[0] || p[1])) begin
                m_buf = 1; m_buf_typ = p[1];
            end
`endif
            if (age < W + A + R) begin
                na = age + 1;
                if (na <= W) begin
                    e_move = 1; e_busy = 1;
                end else if (na <= W + A) begin
                    e_move = 1; e_busy = 1;
                    e_punch = !m_typ; e_kick = m_typ;
                end else begin
                    e_busy = 1;
                end
            end else begin
                m_att = 0;
                if (m_buf) begin
                    m_att = 1; m_t0 = fr; m_typ = m_buf_typ; m_buf = 0;
                    e_move = 1; e_busy = 1;
                end else if (lh) begin
                    m_wait = 1; e_busy = 1;
                end
            end
        end else if (m_wait) begin
            if (lh) e_busy = 1;
            else m_wait = 0;
        end else begin
            e_block = h[2];
            e_shoot = p[3] && !h[2];
            if ((p[0] || p[1]) && !h[2]) begin
                m_att = 1; m_t0 = fr; m_typ = p[1];
                e_move = 1; e_busy = 1;
            end
        end
        for (int i = 0; i < 4; i++) m_prev[i] = h[i];
    endtask

    // One frame: check outputs of frame fr, then drive inputs for frame fr
    task automatic step(input logic r, input logic e, input logic [31:0] k);
        @(negedge frame_clk);
        if (exp_valid) begin
            chk("punch", punch, e_punch);
            chk("kick",  kick,  e_kick);
            chk("block", block, e_block);
            chk("shoot", shoot, e_shoot);
            chk("move",  move,  e_move);
            chk("busy",  busy,  e_busy);
            n_punch += int'(punch); n_kick += int'(kick); n_block += int'(block);
            n_shoot += int'(shoot); n_busy += int'(busy);
            if (punch === 1'b1 && first_punch < 0) first_punch = fr;
        end
        Reset = r; enable = e; keycode = k;
        model(r, e, k);
        exp_valid = 1;
        fr++;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 32'h0);
    endtask

    function automatic logic [31:0] rand_kc();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = alpha[$urandom_range(6)];
        return v;
    endfunction

    initial begin
        int p;
        logic [31:0] kc;
        Reset = 1; enable = 0; keycode = 0;
        step(1, 0, 32'h0);
        step(1, 1, 32'h0);
        step(1, 1, 32'h0);
        // reset state pinned by literals
        chk("reset_punch", punch, 1'b0);
        chk("reset_kick",  kick,  1'b0);
        chk("reset_block", block, 1'b0);
        chk("reset_shoot", shoot, 1'b0);
        chk("reset_move",  move,  1'b0);
        chk("reset_busy",  busy,  1'b0);
        idle_frames(3);

        // 1: held punch key, single attack, re-press gives a second
        clr_counts();
        p = fr;
        for (int i = 0; i < 40; i++) step(0, 1, 32'h0D000000);
        chk_int("t1_punch_len", n_punch, 10);
        chk_int("t1_punch_start", first_punch, p + 7);
        idle_frames(5);
        for (int i = 0; i < 30; i++) step(0, 1, 32'h0D000000);
        idle_frames(5);
        chk_int("t1_repress_total", n_punch, 20);

        // 2: kick and punch edge together -> kick only
        clr_counts();
        step(0, 1, 32'h0E0D0000);
        idle_frames(40);
        chk_int("t2_kick_len", n_kick, 10);
        chk_int("t2_no_punch", n_punch, 0);

        // 3: block held suppresses punch, then release and punch
        clr_counts();
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0F000000);
        for (int i = 0; i < 20; i++) step(0, 1, 32'h0F0D0000);
        idle_frames(3);
        chk_int("t3_block_frames", n_block, 23);
        chk_int("t3_blocked_punch", n_punch, 0);
        p = fr;
        step(0, 1, 32'h0D000000);
        idle_frames(40);
        chk_int("t3_punch_start", first_punch, p + 7);

        // 4: shoot in IDLE pulses once; shoot during ACTIVE is dropped
        clr_counts();
        for (int i = 0; i < 3; i++) step(0, 1, 32'h33000000);
        idle_frames(3);
        chk_int("t4_shoot_idle", n_shoot, 1);
        clr_counts();
        for (int i = 0; i < 8; i++) step(0, 1, 32'h0D000000);
        for (int i = 0; i < 5; i++) step(0, 1, 32'h0D330000);
        idle_frames(40);
        chk_int("t4_shoot_active", n_shoot, 0);

        // 5: enable drop on third ACTIVE frame, then reset mid-WINDUP
        clr_counts();
        for (int i = 0; i < 9; i++) step(0, 1, 32'h0D000000);
        step(0, 0, 32'h0D000000);
        for (int i = 0; i < 30; i++) step(0, 1, 32'h0D000000);
        idle_frames(5);
        chk_int("t5_enable_punch", n_punch, 3);
        chk_int("t5_enable_busy", n_busy, 9);
        clr_counts();
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0D000000);
        step(1, 1, 32'h0);
        idle_frames(30);
        chk_int("t5_reset_busy", n_busy, 3);
        chk_int("t5_reset_punch", n_punch, 0);

        // 6: kick pressed on the 5th RECOVER frame
        clr_counts();
        step(0, 1, 32'h0D000000);
        idle_frames(20);
        step(0, 1, 32'h0E000000);
        idle_frames(50);
`ifdef COMBO_BUFFER_EN
        chk_int("t6_combo_kick", n_kick, 10);
        chk_int("t6_combo_busy", n_busy, 56);
`else
        chk_int("t6_no_combo_kick", n_kick, 0);
        chk_int("t6_no_combo_busy", n_busy, 28);
`endif

        // random traffic against the model
        kc = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) kc = rand_kc();
            step(($urandom_range(255) == 0), ($urandom_range(63) != 0), kc);
        end
        idle_frames(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
